// File: rtl/nios_mult_pkg.sv
// nios_mult_pkg: shared op encoding, partial-product width and count helper
package nios_mult_pkg;
    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULXUU = 2'd1,
        MULXSS = 2'd2,
        MULXSU = 2'd3
    } mult_op_e;

    localparam int PP_W = 16;

    function automatic int pp_count(input int data_w);
        return data_w / PP_W;
    endfunction
endpackage

// File: rtl/nios_mult_pp16.sv
// nios_mult_pp16: registered unsigned 16x16 -> 32 partial product
module nios_mult_pp16
    import nios_mult_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic [PP_W-1:0]     a,
    input  logic [PP_W-1:0]     b,
    output logic [2*PP_W-1:0]   p
);
    // capture the product whenever a new beat enters stage 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) p <= '0;
        else if (en) p <= {{PP_W{1'b0}}, a} * {{PP_W{1'b0}}, b};
    end
endmodule

// File: rtl/nios_mult_pipe.sv
// nios_mult_pipe: two-stage multiplier with valid/ready handshake on both sides.
// Define NIOS_MULT_PIPE_MULX_EN to build the high-half (MULX*) path; without it
// every beat is treated as MUL and only the low-half partial products exist.
module nios_mult_pipe
    import nios_mult_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);
    localparam int N = pp_count(DATA_W);
`ifdef NIOS_MULT_PIPE_MULX_EN
    localparam bit MULX_EN = 1'b1;
    localparam int SUM_W   = 2 * DATA_W;
`else
    localparam bit MULX_EN = 1'b0;
    localparam int SUM_W   = DATA_W;
`endif

    logic              s1_valid;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_free;
    logic              load;
    logic [2*PP_W-1:0] pp [N][N];
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] result;

    // S2 can take a beat when empty or when its current beat leaves this cycle
    assign s2_free  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | s2_free;
    assign load     = in_valid & in_ready;

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (MULX_EN || (i + j < N)) begin : g_pp
                nios_mult_pp16 u_pp (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .en      (load),
                    .a       (in_src1[PP_W*i +: PP_W]),
                    .b       (in_src2[PP_W*j +: PP_W]),
                    .p       (pp[i][j])
                );
            end else begin : g_zero
                assign pp[i][j] = '0;
            end
        end
    end

`ifdef NIOS_MULT_PIPE_MULX_EN
    mult_op_e          op;
    logic              sa;
    logic              sb;
    logic              s1_hi;
    logic [DATA_W-1:0] s1_corr;

    assign op = mult_op_e'(in_op);
    assign sa = (op == MULXSS) || (op == MULXSU);
    assign sb = (op == MULXSS);

    // high half of a signed product = unsigned high half minus each signed
    // operand's partner (when that operand is negative), modulo 2^DATA_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_hi   <= 1'b0;
            s1_corr <= '0;
        end else if (load) begin
            s1_hi   <= (op != MUL);
            s1_corr <= ((sa && in_src1[DATA_W-1]) ? in_src2 : '0)
                     + ((sb && in_src2[DATA_W-1]) ? in_src1 : '0);
        end
    end

    assign result = s1_hi ? sum[SUM_W-1:DATA_W] - s1_corr : sum[DATA_W-1:0];
`else
    logic unused_op;
    assign unused_op = ^in_op;
    assign result    = sum;
`endif

    // weighted sum of the registered partial products
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                sum = sum + (SUM_W'(pp[i][j]) << (PP_W * (i + j)));
    end

    // stage 1 valid/tag follow the operand capture in the partial-product units
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (load) s1_tag <= in_tag;
        end
    end

    // stage 2 holds its beat while the consumer stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= result;
                out_tag    <= s1_tag;
            end
        end
    end
endmodule

// File: doc/nios_mult_pipe.md
NIOS_MULT_PIPE -- requirements
Module: nios_mult_pipe

Interface
REQ-001 Parameter DATA_W, default 32, operand width; SHALL be a multiple of 16 in range 16..64.
REQ-002 Parameter TAG_W, default 5, width of the passthrough destination tag.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 in_op  input  2  operation: 0 MUL (low half), 1 MULXUU, 2 MULXSS, 3 MULXSU (high half; src1 signed, src2 unsigned for SU).
REQ-008 in_src1, in_src2  input  DATA_W  operands.
REQ-009 in_tag  input  TAG_W  opaque tag returned with the result.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_result  output  DATA_W  selected half of the 2*DATA_W product.
REQ-013 out_tag  output  TAG_W  tag of the beat on out_result.

Function
REQ-014 SHALL be a two-stage pipeline. S1 registers the 16x16 partial products and the sign-correction terms. S2 registers the summed product and the half selection.
REQ-015 A beat SHALL transfer on in_valid & in_ready and on out_valid & out_ready.
REQ-016 With out_ready held high, a beat accepted in cycle N SHALL appear with out_valid high in cycle N+2; throughput SHALL be one beat per cycle.
REQ-017 Stage S2 SHALL hold its contents while out_valid & ~out_ready.
- S1 SHALL advance into S2 only when S2 is empty or S2 is transferring.
- in_ready = ~S1_valid | S1_advance.
REQ-018 in_ready SHALL NOT depend combinationally on in_valid.
REQ-019 out_result, out_tag and out_valid SHALL be stable while stalled.
REQ-020 MUL SHALL return product bits [DATA_W-1:0]; the result SHALL be identical for signed and unsigned interpretation.
REQ-021 MULX* SHALL return product bits [2*DATA_W-1:DATA_W], computed with the operand signedness given by in_op.
REQ-022 Signed products SHALL be exact, including the extreme case: -2^(DATA_W-1) * -2^(DATA_W-1) gives high half 2^(DATA_W-2).
REQ-023 A simultaneous input accept and output transfer in a full pipeline SHALL lose and duplicate no beat.
REQ-024 out_tag SHALL equal the in_tag of the same beat; ordering SHALL be strictly FIFO.

Reset
REQ-025 When reset_n is low, S1_valid, S2_valid, out_valid, out_result and out_tag SHALL clear to 0 immediately; in_ready SHALL be 1.
REQ-026 Beats in flight at reset assertion SHALL be discarded; no out_valid SHALL be produced for them after release.
REQ-027 The first accept SHALL be possible in the first clock after reset_n deasserts.

Configuration
REQ-028 Macro NIOS_MULT_PIPE_MULX_EN compiles in the high-half path.
- Defined: all four in_op codes are honoured.
- Undefined: in_op is ignored, every beat is treated as MUL, the sign-correction and upper partial-product logic are absent, and latency and handshake are unchanged.

Structure
REQ-029 Package nios_mult_pkg SHALL hold:
- the in_op encoding enum (MUL, MULXUU, MULXSS, MULXSU);
- the partial-product width constant PP_W = 16;
- the function giving the partial-product count DATA_W/16.
REQ-030 Sub-module nios_mult_pp16 SHALL implement one unsigned 16x16 -> 32 registered partial product with enable and asynchronous clear. It SHALL be instantiated (DATA_W/16)^2 times with MULX_EN, and only for the low-half terms without it.

Verification
REQ-031 Scenario 1 (basic MUL latency): DATA_W=32, MUL 0x0001_0003 * 0x0002_0005, out_ready=1 -> out_result 0x000B_000F exactly two cycles after accept.
REQ-032 Scenario 2 (signed extreme): MULXSS 0x8000_0000 * 0x8000_0000 -> 0x4000_0000.
- MULXUU on the same operands -> 0x4000_0000.
- MULXSU 0xFFFF_FFFF * 0x0000_0002 -> 0xFFFF_FFFF.
REQ-033 Scenario 3 (back-pressure): stream 4 tagged beats with out_ready low for 3 cycles mid-stream -> in_ready falls after two beats are held; all 4 results and tags appear in order, with no duplicates and no drops.
REQ-034 Scenario 4 (reset mid-flight): assert reset_n low with two beats in flight -> out_valid 0 immediately; no result appears after release; the next beat returns correctly at N+2.
REQ-035 Scenario 5 (configuration): build without NIOS_MULT_PIPE_MULX_EN, issue in_op=2 with 0x8000_0000 * 0x8000_0000 -> out_result 0x0000_0000 (low half).
REQ-036 Scenario 6 (width): DATA_W=16 and DATA_W=64 builds; a random 1000-beat stream with random out_ready -> every result matches the reference product for its in_op.
